cle_unlock_seq: RTL and testbench

//  Address-sequence unlock controller for the CLE serial-data window (BA13=0, BA12=1, read, SSER low).

---
 rtl/cle_unlock_seq_if.sv | 22 ++
 rtl/cle_unlock_seq.sv | 195 +++++++++++++++++++
 tb/tb_cle_unlock_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cle_unlock_seq_if.sv
// Bus-side access qualifiers seen by the CLE unlock sequencer.
// The master drives one access per bus_valid pulse; the sequencer only observes.
interface cle_unlock_seq_if;
  logic       bus_valid;
  logic       sser;
  logic [9:0] ba;
  logic       br_w;

  modport master (
    output bus_valid,
    output sser,
    output ba,
    output br_w
  );

  modport slave (
    input bus_valid,
    input sser,
    input ba,
    input br_w
  );
endinterface

// File: rtl/cle_unlock_seq.sv
// Address-sequence unlock controller gating SDRD read strobes for the CLE serial-data window.
// Optional write-relock behaviour is enabled with `define CLE_RELOCK_WRITE_EN.
//
// state   | meaning
// LOCKED  | idle, waiting for the first key nibble
// S1..S3  | 1..3 key nibbles matched, inter-step timer running
// UNLOCK  | window reads produce sdrd_en until the grant count is used up
// LOCKOUT | too many failed attempts, all accesses ignored for LOCKOUT_CYC clocks
module cle_unlock_seq #(
  parameter logic [15:0] KEY         = 16'h2A5C,
  parameter int          TIMEOUT     = 64,
  parameter int          GRANTS      = 8,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCKOUT_CYC = 1024,
  localparam int         FW          = $clog2(MAX_FAIL + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cle_unlock_seq_if.slave       bus,
  output logic                  unlocked,
  output logic                  sdrd_en,
  output logic                  lockout,
  output logic [2:0]            state,
  output logic [FW-1:0]         fail_cnt
);

  localparam int TSPAN = (TIMEOUT > LOCKOUT_CYC) ? TIMEOUT : LOCKOUT_CYC;
  localparam int TW    = $clog2(TSPAN + 1);
  localparam int GW    = $clog2(GRANTS + 1);

  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT);
  localparam logic [TW-1:0] LO_END = TW'(LOCKOUT_CYC);
  localparam logic [TW-1:0] T_SAT  = TW'(TSPAN);
  localparam logic [GW-1:0] G_LOAD = GW'(GRANTS);
  localparam logic [GW-1:0] G_LAST = GW'(1);
  localparam logic [FW-1:0] F_MAX  = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    LOCKED  = 3'd0,
    S1      = 3'd1,
    S2      = 3'd2,
    S3      = 3'd3,
    UNLOCK  = 3'd4,
    LOCKOUT = 3'd5
  } state_e;

  state_e        state_q, state_nxt;
  logic [TW-1:0] timer_q, timer_nxt, timer_inc;
  logic [GW-1:0] grant_q, grant_nxt;
  logic [FW-1:0] fail_q, fail_nxt, fail_inc;
  logic          sdrd_nxt;
  logic          win;
  logic          relock_wr;
  logic [3:0]    nib;
  logic [3:0]    key_exp;
  logic          unused_ba;

  // BA11..BA8 play no part in the window decode or the key match.
  assign unused_ba = ^bus.ba[7:4];

  assign nib = bus.ba[3:0];
  assign win = bus.bus_valid & ~bus.sser & ~bus.ba[9] & bus.ba[8] & bus.br_w;

`ifdef CLE_RELOCK_WRITE_EN
  assign relock_wr = bus.bus_valid & ~bus.sser & ~bus.ba[9] & bus.ba[8] & ~bus.br_w;
`else
  assign relock_wr = 1'b0;
`endif

  assign timer_inc = (timer_q == T_SAT) ? timer_q : timer_q + TW'(1);
  assign fail_inc  = (fail_q == F_MAX) ? fail_q : fail_q + FW'(1);

  always_comb begin
    key_exp = KEY[15:12];
    case (state_q)
      S1:      key_exp = KEY[11:8];
      S2:      key_exp = KEY[7:4];
      S3:      key_exp = KEY[3:0];
      default: key_exp = KEY[15:12];
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    grant_nxt = grant_q;
    fail_nxt  = fail_q;
    sdrd_nxt  = 1'b0;

    case (state_q)
      LOCKED: begin
        timer_nxt = '0;
        if (win && (nib == KEY[15:12])) begin
          state_nxt = S1;
        end
      end

      S1, S2, S3: begin
        // A window access is resolved before a coincident timeout.
        if (win) begin
          timer_nxt = '0;
          if (nib == key_exp) begin
            case (state_q)
              S1:      state_nxt = S2;
              S2:      state_nxt = S3;
              default: begin
                state_nxt = UNLOCK;
                grant_nxt = G_LOAD;
                fail_nxt  = '0;
              end
            endcase
          end else begin
            fail_nxt = fail_inc;
            if (fail_inc == F_MAX) begin
              state_nxt = LOCKOUT;
            end else if (nib == KEY[15:12]) begin
              state_nxt = S1;
            end else begin
              state_nxt = LOCKED;
            end
          end
        end else if (relock_wr) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
        end else if (timer_inc == TO_END) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      UNLOCK: begin
        if (win) begin
          sdrd_nxt  = 1'b1;
          timer_nxt = '0;
          grant_nxt = grant_q - GW'(1);
          if (grant_q == G_LAST) begin
            state_nxt = LOCKED;
          end
        end else if (relock_wr) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
          grant_nxt = '0;
        end else if (timer_inc == TO_END) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
          grant_nxt = '0;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      LOCKOUT: begin
        if (timer_inc == LO_END) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
          fail_nxt  = '0;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      default: begin
        state_nxt = LOCKED;
        timer_nxt = '0;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOCKED;
      timer_q  <= '0;
      grant_q  <= '0;
      fail_q   <= '0;
      sdrd_en  <= 1'b0;
      unlocked <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      timer_q  <= timer_nxt;
      grant_q  <= grant_nxt;
      fail_q   <= fail_nxt;
      sdrd_en  <= sdrd_nxt;
      unlocked <= (state_nxt == UNLOCK);
      lockout  <= (state_nxt == LOCKOUT);
    end
  end

  assign state    = state_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_cle_unlock_seq.sv
// Self-checking bench for cle_unlock_seq: directed scenarios plus random traffic
// checked every clock against an access-level reference model.
module tb_cle_unlock_seq;

  localparam int TIMEOUT     = 64;
  localparam int GRANTS      = 8;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 1024;

`ifdef CLE_RELOCK_WRITE_EN
  localparam bit WR_RELOCK = 1'b1;
`else
  localparam bit WR_RELOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       unlocked;
  logic       sdrd_en;
  logic       lockout;
  logic [2:0] state;
  logic [1:0] fail_cnt;

  always #5 clk = ~clk;

  cle_unlock_seq_if bus ();

  cle_unlock_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .unlocked (unlocked),
    .sdrd_en  (sdrd_en),
    .lockout  (lockout),
    .state    (state),
    .fail_cnt (fail_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int key [4]  = '{2, 10, 5, 12};

  // Reference model: progress through the key, remaining grants, remaining lockout clocks.
  int m_prog;
  int m_grants;
  int m_lock_left;
  int m_idle;
  int m_fails;
  bit m_sdrd;

  task automatic model_reset();
    m_prog = 0; m_grants = 0; m_lock_left = 0; m_idle = 0; m_fails = 0; m_sdrd = 0;
  endtask

  function automatic int exp_state();
    if (m_lock_left > 0) return 5;
    if (m_grants > 0) return 4;
    return m_prog;
  endfunction

  task automatic model_step(input logic v, input logic s, input logic [9:0] a, input logic r);
    bit win, wr;
    int nib;
    win = v & ~s & ~a[9] & a[8] & r;
    wr  = v & ~s & ~a[9] & a[8] & ~r;
    nib = int'(a[3:0]);
    m_sdrd = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_grants > 0) begin
      if (win) begin
        m_sdrd = 1; m_grants--; m_idle = 0;
      end else if (WR_RELOCK && wr) begin
        m_grants = 0; m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin m_grants = 0; m_idle = 0; end
      end
    end else if (m_prog > 0) begin
      if (win) begin
        m_idle = 0;
        if (nib == key[m_prog]) begin
          m_prog++;
          if (m_prog == 4) begin m_prog = 0; m_grants = GRANTS; m_fails = 0; end
        end else begin
          m_fails = (m_fails + 1 > MAX_FAIL) ? MAX_FAIL : m_fails + 1;
          if (m_fails == MAX_FAIL) begin
            m_prog = 0; m_lock_left = LOCKOUT_CYC;
          end else begin
            m_prog = (nib == key[0]) ? 1 : 0;
          end
        end
      end else if (WR_RELOCK && wr) begin
        m_prog = 0; m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin m_prog = 0; m_idle = 0; end
      end
    end else if (win && nib == key[0]) begin
      m_prog = 1; m_idle = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("state",    32'(state),    32'(exp_state()));
    chk("unlocked", 32'(unlocked), 32'(m_grants > 0));
    chk("lockout",  32'(lockout),  32'(m_lock_left > 0));
    chk("sdrd_en",  32'(sdrd_en),  32'(m_sdrd));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_fails));
  endtask

  task automatic cyc(input logic v, input logic s, input logic [9:0] a, input logic r);
    bus.bus_valid = v; bus.sser = s; bus.ba = a; bus.br_w = r;
    model_step(v, s, a, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rd(input int nib);
    cyc(1'b1, 1'b0, {2'b01, 4'($urandom_range(0, 15)), 4'(nib)}, 1'b1);
  endtask

  task automatic wr_win();
    cyc(1'b1, 1'b0, {2'b01, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))}, 1'b0);
  endtask

  // Bus activity that never qualifies: serial select deasserted.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'($urandom_range(0, 1)), 1'b1, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
  endtask

  task automatic unlock_seq();
    rd(2); gap(2); rd(10); gap(2); rd(5); gap(2); rd(12);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int nib;
    bus.bus_valid = 1'b0; bus.sser = 1'b1; bus.ba = '0; bus.br_w = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_sdrd", 32'(sdrd_en), 32'd0);
    chk("rst_lockout", 32'(lockout), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    rst_n = 1'b1;
    gap(3);

    // Key 2,A,5,C then eight grants, ninth read ignored
    unlock_seq();
    chk("t1_unlocked", 32'(unlocked), 32'd1);
    for (int g = 0; g < GRANTS; g++) begin
      gap(2);
      rd($urandom_range(0, 15));
      chk("t1_sdrd", 32'(sdrd_en), 32'd1);
    end
    chk("t1_relocked", 32'(unlocked), 32'd0);
    gap(2);
    rd(7);
    chk("t1_ninth_sdrd", 32'(sdrd_en), 32'd0);

    // One failed attempt, then a successful unlock clears the count
    rd(2); rd(10); rd(7);
    chk("t2_fail", 32'(fail_cnt), 32'd1);
    chk("t2_state", 32'(state), 32'd0);
    unlock_seq();
    chk("t2_unlocked", 32'(unlocked), 32'd1);
    chk("t2_fail_clr", 32'(fail_cnt), 32'd0);
    gap(TIMEOUT);
    chk("t2_timeout", 32'(unlocked), 32'd0);

    // Three failures force lockout; key ignored during lockout
    rd(2); rd(7);
    rd(2); rd(10); rd(1);
    rd(2); rd(3);
    chk("t3_lockout", 32'(lockout), 32'd1);
    rd(2); rd(10); rd(5); rd(12);
    gap(LOCKOUT_CYC - 5);
    chk("t3_still_locked", 32'(lockout), 32'd1);
    gap(1);
    chk("t3_lockout_end", 32'(lockout), 32'd0);
    chk("t3_fail_clr", 32'(fail_cnt), 32'd0);

    // Inter-step timeout keeps the fail count; a step on the last clock still advances
    rd(2); rd(7);
    rd(2); gap(TIMEOUT - 1);
    chk("t4_before_to", 32'(state), 32'd1);
    gap(1);
    chk("t4_after_to", 32'(state), 32'd0);
    chk("t4_fail_kept", 32'(fail_cnt), 32'd1);
    rd(2); gap(TIMEOUT - 1); rd(10);
    chk("t4_edge_step", 32'(state), 32'd2);
    rd(5); rd(12);
    chk("t4_unlocked", 32'(unlocked), 32'd1);

    // Asynchronous reset with grants outstanding
    rd(1); rd(1); rd(1);
    rst_n = 1'b0;
    #2;
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_unlocked", 32'(unlocked), 32'd0);
    chk("t5_sdrd", 32'(sdrd_en), 32'd0);
    chk("t5_fail", 32'(fail_cnt), 32'd0);
    model_reset();
    bus.bus_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(2);
    chk("t5_no_sdrd", 32'(sdrd_en), 32'd0);

    // Window write while unlocked
    rd(10); rd(5); rd(12);
    wr_win();
`ifdef CLE_RELOCK_WRITE_EN
    chk("t6_write_relock", 32'(state), 32'd0);
`else
    chk("t6_write_ignored", 32'(unlocked), 32'd1);
`endif
    gap(TIMEOUT);

    // Random traffic against the model
    for (int it = 0; it < 2500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        nib = ($urandom_range(0, 7) != 0) ? key[m_prog] : $urandom_range(0, 15);
        rd(nib);
      end else if (r < 44) begin
        wr_win();
      end else if (r < 46) begin
        gap($urandom_range(55, 70));
      end else begin
        gap(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
